// File: rtl/pc_gen_pkg.sv
// Shared definitions for the next-PC generator: redirect-source priority encoding,
// FSM state encoding and default geometry constants.
package pc_gen_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INC    = 4;

    // Numeric order is the redirect priority: a larger value wins.
    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_SEQ    = 3'd1,
        SRC_HELD   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_JUMP   = 3'd4,
        SRC_BRANCH = 3'd5,
        SRC_EXC    = 3'd6
    } src_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// push+pop replaces the top in place, flush empties it in one cycle.
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W:0]    count_reg;

    assign top_ptr = wr_ptr_reg - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign empty   = (count_reg == '0);

    // Storage carries no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[pop ? top_ptr : wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else if (push && !pop) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (count_reg != FULL_CNT) begin
                count_reg <= count_reg + (PTR_W + 1)'(1);
            end
        end else if (pop && !push) begin
            wr_ptr_reg <= top_ptr;
            count_reg  <= count_reg - (PTR_W + 1)'(1);
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage next-PC generator with prioritised redirects held across stalls.
// Define PC_GEN_RAS_EN to add return-address-stack prediction for ret_valid.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                INC       = DEF_INC,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_pc,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic              call_valid,
    input  logic [ADDR_W-1:0] call_ret_pc,
    input  logic              ret_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic              redirect_pend,
    output logic              ras_empty,
    output logic              ras_underflow
);

    state_e            state_reg, state_next;
    src_e              held_src_reg, held_src_next;
    logic [ADDR_W-1:0] held_pc_reg, held_pc_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    src_e              fresh_src;
    logic [ADDR_W-1:0] fresh_pc;
    logic              fresh_wins;
    logic              exc_taken;
    logic              ret_taken;
    logic              ras_empty_int;
    logic [ADDR_W-1:0] ras_top;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    assign pc            = pc_reg;
    assign pc_plus_inc   = pc_reg + ADDR_W'(INC);
    assign redirect_pend = (state_reg == ST_HOLD);

    always_comb begin
        fresh_src = SRC_NONE;
        fresh_pc  = '0;
        if (exc_valid) begin
            fresh_src = SRC_EXC;
            fresh_pc  = align(exc_pc);
        end else if (branch_valid) begin
            fresh_src = SRC_BRANCH;
            fresh_pc  = align(branch_pc);
        end else if (jump_valid) begin
            fresh_src = SRC_JUMP;
            fresh_pc  = align(jump_pc);
        end else if (ret_valid && !ras_empty_int) begin
            fresh_src = SRC_RET;
            fresh_pc  = align(ras_top);
        end
    end

    // In HOLD only a strictly higher-priority source may displace the held one.
    assign fresh_wins = (fresh_src != SRC_NONE) &&
                        ((state_reg == ST_RUN) || (fresh_src > held_src_reg));
    assign exc_taken  = fresh_wins && (fresh_src == SRC_EXC);
    assign ret_taken  = fresh_wins && (fresh_src == SRC_RET);

    always_comb begin
        state_next    = state_reg;
        held_src_next = held_src_reg;
        held_pc_next  = held_pc_reg;
        pc_next       = pc_reg;
        case (state_reg)
            ST_RUN: begin
                if (pc_write) begin
                    pc_next = fresh_wins ? fresh_pc : pc_plus_inc;
                end else if (fresh_wins) begin
                    state_next    = ST_HOLD;
                    held_src_next = fresh_src;
                    held_pc_next  = fresh_pc;
                end
            end
            ST_HOLD: begin
                if (pc_write) begin
                    pc_next       = fresh_wins ? fresh_pc : held_pc_reg;
                    state_next    = ST_RUN;
                    held_src_next = SRC_NONE;
                end else if (fresh_wins) begin
                    held_src_next = fresh_src;
                    held_pc_next  = fresh_pc;
                end
            end
            default: begin
                state_next    = ST_RUN;
                held_src_next = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            held_src_reg <= SRC_NONE;
            held_pc_reg  <= '0;
            pc_reg       <= RESET_VEC;
        end else begin
            state_reg    <= state_next;
            held_src_reg <= held_src_next;
            held_pc_reg  <= held_pc_next;
            pc_reg       <= pc_next;
        end
    end

`ifdef PC_GEN_RAS_EN
    logic ret_empty_hit;
    logic underflow_reg;

    // A ret that would have won arbitration in RUN but finds the stack empty.
    assign ret_empty_hit = ret_valid && !exc_valid && !branch_valid && !jump_valid &&
                           ras_empty_int && (state_reg == ST_RUN);

    pc_gen_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (call_valid && pc_write && !exc_taken),
        .pop       (ret_taken),
        .flush     (exc_taken),
        .push_data (call_ret_pc),
        .top       (ras_top),
        .empty     (ras_empty_int)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= ret_empty_hit;
        end
    end

    assign ras_empty     = ras_empty_int;
    assign ras_underflow = underflow_reg;
`else
    logic unused_ras_inputs;

    assign ras_empty_int     = 1'b1;
    assign ras_top           = '0;
    assign ras_empty         = 1'b1;
    assign ras_underflow     = 1'b0;
    assign unused_ras_inputs = ^{call_valid, call_ret_pc, ret_taken};
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed cases then random stimulus against
// a queue-based reference model (RAS cases compiled in only with PC_GEN_RAS_EN).
module tb_pc_gen_unit;

    localparam int ADDR_W = 32;
    localparam int INC    = 4;
    localparam int DEPTH  = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_write;
    logic              exc_valid, branch_valid, jump_valid, call_valid, ret_valid;
    logic [ADDR_W-1:0] exc_pc, branch_pc, jump_pc, call_ret_pc;
    logic [ADDR_W-1:0] pc, pc_plus_inc;
    logic              redirect_pend, ras_empty, ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state: fetch PC, pending redirect (priority 4=exc..1=ret), RAS as a queue.
    logic [31:0] m_pc;
    bit          m_pend;
    int          m_held_prio;
    logic [31:0] m_held_pc;
    logic [31:0] m_ras[$];
    bit          m_uflow;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (32'h0),
        .INC       (INC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .branch_valid  (branch_valid),
        .branch_pc     (branch_pc),
        .jump_valid    (jump_valid),
        .jump_pc       (jump_pc),
        .call_valid    (call_valid),
        .call_ret_pc   (call_ret_pc),
        .ret_valid     (ret_valid),
        .pc            (pc),
        .pc_plus_inc   (pc_plus_inc),
        .redirect_pend (redirect_pend),
        .ras_empty     (ras_empty),
        .ras_underflow (ras_underflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_pc        = 32'h0;
        m_pend      = 1'b0;
        m_held_prio = 0;
        m_held_pc   = 32'h0;
        m_ras.delete();
        m_uflow     = 1'b0;
    endtask

    task automatic model_step();
        int          prio;
        logic [31:0] tgt;
        bit          take;
        prio    = 0;
        tgt     = 32'h0;
        m_uflow = 1'b0;
        if (exc_valid) begin
            prio = 4; tgt = word_align(exc_pc);
        end else if (branch_valid) begin
            prio = 3; tgt = word_align(branch_pc);
        end else if (jump_valid) begin
            prio = 2; tgt = word_align(jump_pc);
        end else if (RAS_ON && ret_valid) begin
            if (m_ras.size() > 0) begin
                prio = 1; tgt = word_align(m_ras[$]);
            end else if (!m_pend) begin
                m_uflow = 1'b1;
            end
        end
        take = (prio > 0) && (!m_pend || prio > m_held_prio);
        if (pc_write) begin
            if (take)        m_pc = tgt;
            else if (m_pend) m_pc = m_held_pc;
            else             m_pc = m_pc + 32'(INC);
            m_pend = 1'b0;
        end else if (take) begin
            m_pend      = 1'b1;
            m_held_prio = prio;
            m_held_pc   = tgt;
        end
        if (RAS_ON) begin
            if (take && prio == 4) begin
                m_ras.delete();
            end else begin
                if (take && prio == 1) void'(m_ras.pop_back());
                if (call_valid && pc_write) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(call_ret_pc);
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("pc", pc, m_pc);
        check_val("pc_plus_inc", pc_plus_inc, m_pc + 32'(INC));
        check_val("redirect_pend", 32'(redirect_pend), 32'(m_pend));
        check_val("ras_empty", 32'(ras_empty), RAS_ON ? 32'(m_ras.size() == 0) : 32'd1);
        check_val("ras_underflow", 32'(ras_underflow), 32'(m_uflow));
    endtask

    task automatic clear_inputs();
        pc_write     = 1'b1;
        exc_valid    = 1'b0; exc_pc      = '0;
        branch_valid = 1'b0; branch_pc   = '0;
        jump_valid   = 1'b0; jump_pc     = '0;
        call_valid   = 1'b0; call_ret_pc = '0;
        ret_valid    = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        $display("cyc %0d pw=%0b exc=%0b br=%0b jmp=%0b call=%0b ret=%0b -> pc=0x%08h pend=%0b empty=%0b uflow=%0b",
                 cyc, pc_write, exc_valid, branch_valid, jump_valid, call_valid, ret_valid,
                 pc, redirect_pend, ras_empty, ras_underflow);
        compare_all();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("reset_pc", pc, 32'h0);
        check_val("reset_pend", 32'(redirect_pend), 32'd0);
        check_val("reset_empty", 32'(ras_empty), 32'd1);
        check_val("reset_uflow", 32'(ras_underflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset.
        cycle(); check_val("t1_pc1", pc, 32'h4);
        cycle(); check_val("t1_pc2", pc, 32'h8);
        cycle(); check_val("t1_pc3", pc, 32'hC);

        // Branch held across a stall, low bits forced to zero.
        jump_valid = 1'b1; jump_pc = 32'h100;
        cycle(); check_val("t2_pc100", pc, 32'h100);
        clear_inputs(); pc_write = 1'b0; branch_valid = 1'b1; branch_pc = 32'h2003;
        cycle(); check_val("t2_pend", 32'(redirect_pend), 32'd1); check_val("t2_hold", pc, 32'h100);
        clear_inputs();
        cycle(); check_val("t2_pc", pc, 32'h2000); check_val("t2_nopend", 32'(redirect_pend), 32'd0);

        // Exception beats jump; a later jump cannot displace a held exception.
        exc_valid = 1'b1; exc_pc = 32'h80; jump_valid = 1'b1; jump_pc = 32'h400;
        cycle(); check_val("t3_exc", pc, 32'h80);
        clear_inputs(); pc_write = 1'b0; exc_valid = 1'b1; exc_pc = 32'h80;
        cycle();
        clear_inputs(); pc_write = 1'b0; jump_valid = 1'b1; jump_pc = 32'h400;
        cycle(); check_val("t3_still_pend", 32'(redirect_pend), 32'd1);
        clear_inputs();
        cycle(); check_val("t3_held_exc", pc, 32'h80);

        // Wrap-around of the sequential increment.
        jump_valid = 1'b1; jump_pc = 32'hFFFF_FFFC;
        cycle(); check_val("t4_top", pc, 32'hFFFF_FFFC); check_val("t4_inc", pc_plus_inc, 32'h0);
        clear_inputs();
        cycle(); check_val("t4_wrap", pc, 32'h0);

`ifdef PC_GEN_RAS_EN
        // Calls then returns in LIFO order, then an underflow.
        for (int i = 1; i <= 3; i++) begin
            clear_inputs(); call_valid = 1'b1; call_ret_pc = 32'(i * 16);
            cycle();
        end
        for (int i = 3; i >= 1; i--) begin
            clear_inputs(); ret_valid = 1'b1;
            cycle(); check_val("t5_ret", pc, 32'(i * 16));
        end
        clear_inputs(); ret_valid = 1'b1;
        cycle(); check_val("t5_uflow", 32'(ras_underflow), 32'd1); check_val("t5_seq", pc, 32'h14);
        clear_inputs();
        cycle(); check_val("t5_uflow_clr", 32'(ras_underflow), 32'd0);

        // Overfilled stack then exception flush.
        for (int i = 0; i < 5; i++) begin
            clear_inputs(); call_valid = 1'b1; call_ret_pc = 32'(32'h1000 + i * 4);
            cycle();
        end
        check_val("t6_full", 32'(ras_empty), 32'd0);
        clear_inputs(); exc_valid = 1'b1; exc_pc = 32'h200;
        cycle(); check_val("t6_flush", 32'(ras_empty), 32'd1);
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            clear_inputs();
            pc_write     = ($urandom_range(99) < 75);
            exc_valid    = ($urandom_range(99) < 3);
            branch_valid = ($urandom_range(99) < 8);
            jump_valid   = ($urandom_range(99) < 6);
            call_valid   = ($urandom_range(99) < 12);
            ret_valid    = ($urandom_range(99) < 12);
            exc_pc       = $urandom;
            branch_pc    = $urandom;
            jump_pc      = $urandom;
            call_ret_pc  = $urandom;
            cycle();
        end

        // Asynchronous reset while a redirect is held.
        clear_inputs(); pc_write = 1'b0; branch_valid = 1'b1; branch_pc = 32'h3000;
        cycle(); check_val("t6_pend_before_rst", 32'(redirect_pend), 32'd1);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("t6_rst_pc", pc, 32'h0);
        check_val("t6_rst_pend", 32'(redirect_pend), 32'd0);
        check_val("t6_rst_empty", 32'(ras_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(); check_val("t6_after_rst", pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
